avalon_multi_timer: RTL and testbench
=====================================

// Module: avalon_multi_timer
// PURPOSE
//  Parametrised N-channel Avalon-MM interval timer; successor to the single-channel 16-bit-bus system timer.
//  Each channel is an independent down-counter with a period register, snapshot, one-shot/continuous modes and an IRQ.
//  Adds a shared clock prescaler, a 32-bit data bus and an optional per-channel PWM compare output.
//  Sits on the processor's Avalon bus. Its irq feeds the CPU interrupt controller.
// PARAMETERS
//  NUM_CH          2         number of channels, 1..8
//  CNT_W           32        counter/period width, 8..32
//  PRESCALE        1         counter tick every PRESCALE clk cycles, 1..65536 (1 = every cycle)
//  DEFAULT_PERIOD  49999     reset value of every period register and counter
// PORTS
//  clk        in   1                      system clock
//  reset_n    in   1                      asynchronous, active-low reset
//  chipselect in   1                      Avalon slave select
//  address    in   3+clog2(NUM_CH)        [2:0] register, upper bits channel index
//  write_n    in   1                      active-low write strobe
//  writedata  in   32                     write data
//  readdata   out  32                     registered read data, 1-cycle latency
//  irq        out  1                      OR of irq_vec
//  irq_vec    out  NUM_CH                 per-channel interrupt
//  pwm_out    out  NUM_CH                 per-channel PWM (TIMER_PWM_EN only, else 0)
// BEHAVIOUR
//  Register map, per channel (reg = address[2:0]); unused bits read 0:
//   0 STATUS  [1]=RUN [0]=TO. Any write clears TO.
//   1 CONTROL [3]=STOP [2]=START (write-only strobes) [1]=CONT [0]=ITO. Reads return [1:0].
//   2 PERIOD  [CNT_W-1:0]
//   3 SNAP    write (any data) captures counter; read returns captured value
//   4 COMPARE [CNT_W-1:0], PWM only. Regs 5-7 and channels >= NUM_CH read 0; writes to them are ignored.
//  Reset: readdata=0, irq=0, irq_vec=0, pwm_out=0, counters=DEFAULT_PERIOD, periods=DEFAULT_PERIOD.
//   Also cleared at reset: CONTROL, SNAP, COMPARE, RUN, TO, prescaler.
//  Prescaler: one shared counter; tick=1 for one clk every PRESCALE cycles. PRESCALE=1 gives tick=1 always.
//  Counter, per channel, evaluated at each clk edge:
//   - force_reload (registered 1 cycle after a PERIOD write): counter<=PERIOD and RUN<=0; ignores tick.
//   - else if RUN & tick: at 0, counter<=PERIOD; otherwise counter<=counter-1.
//   - counter wraps only via reload, never below 0.
//  RUN control: START sets RUN. Else STOP, force_reload, or (counter==0 & ~CONT) clears it. START+STOP in one write -> START wins.
//  TO: set on rising edge of (counter==0), i.e. zero now and not zero the previous clk.
//   A new timeout event in the same cycle as a STATUS write -> TO=1 (event wins).
//   PERIOD=0 in CONT mode -> counter stays 0 and TO is set once until cleared.
//  irq_vec[i] = TO[i] & ITO[i], combinational from registers; irq = |irq_vec.
//  Read: readdata <= mux(address) on every clk edge, chipselect ignored. Data valid the cycle after address is presented.
//  SNAP capture samples the counter value before the same-cycle update.
//  Writes to different channels never interact; only the prescaler is shared.
// CONFIGURATION
//  TIMER_PWM_EN defined:
//   - COMPARE register present.
//   - pwm_out[i] registered = RUN[i] & (counter[i] < COMPARE[i]).
//   - COMPARE=0 -> pwm_out constant 0; COMPARE>PERIOD -> 1 while running.
//  TIMER_PWM_EN undefined: no COMPARE storage, reg 4 reads 0, pwm_out tied 0.
// TESTING
//  1 Reset; read ch0 PERIOD -> 49999, STATUS -> 0, irq=0.
//  2 ch0 PERIOD=5, CONTROL=0x7 (START|CONT|ITO), PRESCALE=1.
//    -> TO/irq rise 7 cycles after START write, then every 6 cycles. STATUS write drops irq next cycle.
//  3 ch1 PERIOD=3, CONTROL=0x4 (one-shot) -> counter 3,2,1,0, RUN clears at 0, counter holds 0, TO=1, irq_vec[1]=0 (ITO=0).
//  4 ch0 running; write PERIOD=100 mid-count.
//    -> RUN=0 two cycles later, counter=100. CONTROL=0xC -> RUN=1 (START wins).
//  5 ch0 counting; write SNAP; read SNAP -> value captured that cycle. Counter unaffected.
//    Reset_n pulsed mid-count -> all reset values immediately.
//  6 TIMER_PWM_EN, PRESCALE=4, PERIOD=9, COMPARE=3, CONT -> counter steps every 4 clk; pwm_out high for 12 of every 40 clk.

Source files
------------

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: N-channel Avalon-MM interval timer with a shared prescaler.
// Define TIMER_PWM_EN to add the per-channel COMPARE register and pwm_out.
module avalon_multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 32,
  parameter int PRESCALE = 1,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           chipselect,
  input  logic [3+$clog2(NUM_CH)-1:0]    address,
  input  logic                           write_n,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  output logic                           irq,
  output logic [NUM_CH-1:0]              irq_vec,
  output logic [NUM_CH-1:0]              pwm_out
);
  localparam int AW = 3 + $clog2(NUM_CH);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_PERIOD);
  logic [PW-1:0] pre;
  logic tick, wr;
  logic [AW-1:0] ch;
  logic [2:0] rsel;
  logic [31:0] rd;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] snap [NUM_CH];
  logic [CNT_W-1:0] cmp [NUM_CH];
  logic [NUM_CH-1:0] run, to, cont, ito, reload, zero_d;
  logic [NUM_CH-1:0] w_stat, w_ctrl, w_per, w_snap, w_cmp, start, stop;

  assign tick = pre == PW'(PRESCALE - 1);
  assign wr = chipselect & ~write_n;
  assign rsel = address[2:0];
  assign ch = address >> 3;
  assign irq_vec = to & ito;
  assign irq = |irq_vec;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pre <= '0;
    else pre <= tick ? '0 : pre + PW'(1);

  always_comb begin
    w_stat = '0;
    w_ctrl = '0;
    w_per = '0;
    w_snap = '0;
    w_cmp = '0;
    start = '0;
    stop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_stat[i] = wr && ch == AW'(i) && rsel == 3'd0;
      w_ctrl[i] = wr && ch == AW'(i) && rsel == 3'd1;
      w_per[i] = wr && ch == AW'(i) && rsel == 3'd2;
      w_snap[i] = wr && ch == AW'(i) && rsel == 3'd3;
      w_cmp[i] = wr && ch == AW'(i) && rsel == 3'd4;
      start[i] = w_ctrl[i] && writedata[2];
      stop[i] = w_ctrl[i] && writedata[3];
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= DEF;
        period[i] <= DEF;
        snap[i] <= '0;
      end
      run <= '0;
      to <= '0;
      cont <= '0;
      ito <= '0;
      reload <= '0;
      zero_d <= {NUM_CH{DEFAULT_PERIOD == 0}};
    end else
      for (int i = 0; i < NUM_CH; i++) begin
        reload[i] <= w_per[i];
        zero_d[i] <= cnt[i] == '0;
        if (w_per[i]) period[i] <= writedata[CNT_W-1:0];
        if (w_snap[i]) snap[i] <= cnt[i];
        if (w_ctrl[i]) {cont[i], ito[i]} <= writedata[1:0];
        // START on an expired one-shot reloads so the channel can be rearmed
        if (reload[i] || (start[i] && cnt[i] == '0)) cnt[i] <= period[i];
        else if (run[i] && tick) cnt[i] <= cnt[i] != '0 ? cnt[i] - CNT_W'(1) : cont[i] ? period[i] : cnt[i];
        if (start[i]) run[i] <= 1'b1;
        else if (stop[i] || reload[i] || (cnt[i] == '0 && !cont[i])) run[i] <= 1'b0;
        if (cnt[i] == '0 && !zero_d[i]) to[i] <= 1'b1;
        else if (w_stat[i]) to[i] <= 1'b0;
      end

`ifdef TIMER_PWM_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) cmp[i] <= '0;
      pwm_out <= '0;
    end else
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cmp[i]) cmp[i] <= writedata[CNT_W-1:0];
        pwm_out[i] <= run[i] && cnt[i] < cmp[i];
      end
`else
  always_comb
    for (int i = 0; i < NUM_CH; i++) cmp[i] = w_cmp[i] ? '0 : '0;
  assign pwm_out = '0;
`endif

  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == AW'(i))
        rd = rsel == 3'd0 ? {30'd0, run[i], to[i]} :
             rsel == 3'd1 ? {30'd0, cont[i], ito[i]} :
             rsel == 3'd2 ? 32'(period[i]) :
             rsel == 3'd3 ? 32'(snap[i]) :
             rsel == 3'd4 ? 32'(cmp[i]) : '0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= rd;
endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb_avalon_multi_timer: directed scoreboard bench for avalon_multi_timer.
// A second instance with PRESCALE=4 shares the bus to exercise the prescaler.
module tb_avalon_multi_timer;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [3:0] address = '0;
  logic [31:0] writedata = '0, readdata, readdata2;
  logic irq, irq2;
  logic [1:0] irq_vec, irq_vec2, pwm_out, pwm_out2;
  typedef struct {int kind; string name; logic [31:0] exp;} item_t;
  item_t q[$];
  logic req = 0, vld = 0;
  int checks = 0, errors = 0, pwm_hi = 0, pwm_hi2 = 0;
`ifdef TIMER_PWM_EN
  localparam int CMP_RD = 3, PWM_HI = 24;
`else
  localparam int CMP_RD = 0, PWM_HI = 0;
`endif

  always #5 clk = ~clk;

  avalon_multi_timer dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
  );

  avalon_multi_timer #(.PRESCALE(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .irq(irq2), .irq_vec(irq_vec2), .pwm_out(pwm_out2)
  );

  // kind: -1 none, 0 readdata, 1 readdata2, 2 flags, 3 pwm high counts
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input int k, input logic [31:0] e, input string nm);
    item_t it;
    @(negedge clk);
    chipselect = w || k == 0 || k == 1;
    write_n = !w;
    address = a;
    writedata = d;
    req = k >= 0;
    it.kind = k;
    it.name = nm;
    it.exp = e;
    if (k >= 0) q.push_back(it);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, a, d, -1, '0, "");
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    bus(1'b0, a, '0, 0, e, nm);
  endtask

  task automatic rd2(input logic [3:0] a, input logic [31:0] e, input string nm);
    bus(1'b0, a, '0, 1, e, nm);
  endtask

  task automatic fl(input logic [31:0] e, input string nm);
    bus(1'b0, 4'd0, '0, 2, e, nm);
  endtask

  task automatic idle();
    bus(1'b0, 4'd0, '0, -1, '0, "");
  endtask

  always @(posedge clk) vld <= req;

  always @(negedge clk)
    if (vld) begin
      item_t it;
      logic [31:0] act;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL underflow: output sampled with no expectation queued");
      end else begin
        it = q.pop_front();
        act = it.kind == 0 ? readdata :
              it.kind == 1 ? readdata2 :
              it.kind == 2 ? 32'({pwm_out2, pwm_out, irq_vec, irq}) :
              {pwm_hi2[15:0], pwm_hi[15:0]};
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", it.name, act, it.exp);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rd(4'd2, 32'd0, "readdata in reset");
    fl(32'd0, "flags in reset");
    @(negedge clk);
    reset_n = 1;
    req = 0;
    rd(4'd2, 32'd49999, "ch0 period reset");
    rd(4'd0, 32'd0, "ch0 status reset");
    rd(4'd1, 32'd0, "ch0 control reset");
    rd(4'd10, 32'd49999, "ch1 period reset");
    rd(4'd5, 32'd0, "reg5 reads zero");
    rd(4'd4, 32'd0, "compare reset");
    fl(32'd0, "irq reset");
    rd2(4'd2, 32'd49999, "dut2 period reset");
    wr(4'd2, 32'd5);
    wr(4'd1, 32'h7);
    for (int k = 2; k <= 6; k++) fl(32'd0, "t2 before timeout");
    fl(32'd3, "t2 first timeout");
    rd(4'd0, 32'd3, "t2 status run+to");
    wr(4'd0, 32'd0);
    for (int k = 10; k <= 12; k++) fl(32'd0, "t2 irq cleared");
    fl(32'd3, "t2 second timeout");
    wr(4'd0, 32'd0);
    wr(4'd2, 32'd100);
    rd(4'd0, 32'd2, "t4 run before reload");
    rd(4'd0, 32'd0, "t4 stopped by reload");
    wr(4'd1, 32'hC);
    rd(4'd0, 32'd2, "t4 start wins");
    rd(4'd1, 32'd0, "t4 control readback");
    wr(4'd3, 32'd0);
    rd(4'd3, 32'd98, "t5 snap a");
    wr(4'd3, 32'd0);
    rd(4'd3, 32'd96, "t5 snap b");
    wr(4'd10, 32'd3);
    wr(4'd9, 32'h4);
    wr(4'd11, 32'd0);
    rd(4'd11, 32'd3, "t3 snap 3");
    wr(4'd11, 32'd0);
    rd(4'd11, 32'd1, "t3 snap 1");
    rd(4'd8, 32'd1, "t3 one-shot status");
    fl(32'd0, "t3 no irq without ito");
    wr(4'd11, 32'd0);
    rd(4'd11, 32'd0, "t3 counter holds 0");
    rd(4'd0, 32'd2, "t3 ch0 unaffected");
    rd(4'd2, 32'd100, "ch0 period before reset");
    bus(1'b0, 4'd2, '0, 0, 32'd0, "readdata async reset");
    #2 reset_n = 0;
    fl(32'd0, "flags async reset");
    @(negedge clk);
    reset_n = 1;
    req = 0;
    wr(4'd2, 32'd9);
    wr(4'd4, 32'd3);
    wr(4'd1, 32'h6);
    repeat (4) idle();
    wr(4'd3, 32'd0);
    rd2(4'd3, 32'd8, "t6 prescaled snap a");
    rd(4'd3, 32'd5, "t6 unscaled snap a");
    idle();
    wr(4'd3, 32'd0);
    rd2(4'd3, 32'd7, "t6 prescaled snap b");
    rd(4'd3, 32'd1, "t6 unscaled snap b");
    rd(4'd4, CMP_RD, "t6 compare readback");
    idle();
    pwm_hi = 0;
    pwm_hi2 = 0;
    repeat (80) begin
      @(negedge clk);
      pwm_hi += int'(pwm_out[0]);
      pwm_hi2 += int'(pwm_out2[0]);
    end
    bus(1'b0, 4'd0, '0, 3, {16'(PWM_HI), 16'(PWM_HI)}, "t6 pwm high cycles");
    repeat (3) idle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
